// File: rtl/pll_supervisor_pkg.sv
// -----------------------------------------------------------------------------
// pll_supervisor_pkg
// Shared types and constants for the PLL supervisor block.
//   state_t     : 3-bit FSM state, ST_* encodings are visible on state_o
//   CFG_W       : width of each PLL divider select (IDSEL/FBDSEL/ODSEL)
//   LOSS_W      : width of the saturating lock-loss counter
//   RETRY_W     : width of the failed-attempt counter
//   max_int     : elaboration-time helper used to size the shared timer
//   holds_pll_reset : which states keep the PLL in reset
// -----------------------------------------------------------------------------
package pll_supervisor_pkg;

    localparam int CFG_W   = 6;
    localparam int LOSS_W  = 8;
    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_RST       = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4,
        ST_RECONF    = 3'd5
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The PLL is only released while it is trying to lock or running;
    // reset pulses, reprogramming and the give-up state all hold it.
    function automatic logic holds_pll_reset(input state_t s);
        return (s == ST_RST) || (s == ST_FAIL) || (s == ST_RECONF);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Multi-flop synchroniser for a single asynchronous level signal.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage
//   d      : asynchronous input
//   q      : input after STAGES flops in the clk domain
// Parameter STAGES must be at least 2.
// -----------------------------------------------------------------------------
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the raw input through the chain; only the last stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// -----------------------------------------------------------------------------
// pll_supervisor
// Brings up the composite-video PLL: pulses its reset, qualifies the
// asynchronous lock indication, retries failed lock attempts with a timeout
// and hands a clean reset / ready flag to the downstream video logic.
//
// Ports
//   clkin          : board reference clock, all logic runs on it
//   rst_n          : asynchronous active-low reset
//   pll_lock       : raw PLL LOCK, asynchronous
//   pll_reset      : PLL RESET pin, active high
//   sys_rst_n      : downstream reset, active low, released only in RUN
//   pll_ready      : high only in RUN
//   pll_fail       : high only in FAIL
//   retry_cnt      : failed lock attempts since the last RUN
//   lock_loss_cnt  : saturating count of lock losses seen while in RUN
//   state_o        : encoded FSM state for debug
//
// Optional feature, macro PLL_SUPERVISOR_DYN_EN: run-time divider
// reprogramming through a valid/ready handshake
//   cfg_valid, cfg_ready, cfg_idsel, cfg_fbdsel, cfg_odsel  : request side
//   pll_idsel, pll_fbdsel, pll_odsel                        : to the PLL
// A zero divider select means "use the static divider parameters".
// -----------------------------------------------------------------------------
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 3,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    output logic                 pll_reset,
    output logic                 sys_rst_n,
    output logic                 pll_ready,
    output logic                 pll_fail,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [LOSS_W-1:0]    lock_loss_cnt,
    output logic [2:0]           state_o
`ifdef PLL_SUPERVISOR_DYN_EN
   ,input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CFG_W-1:0]     cfg_idsel,
    input  logic [CFG_W-1:0]     cfg_fbdsel,
    input  logic [CFG_W-1:0]     cfg_odsel,
    output logic [CFG_W-1:0]     pll_idsel,
    output logic [CFG_W-1:0]     pll_fbdsel,
    output logic [CFG_W-1:0]     pll_odsel
`endif
);

    // One timer is shared by every timed state, so it is sized for the
    // longest interval; it is cleared on every state change and never wraps.
    localparam int MAX_CYC = max_int(max_int(RST_PULSE_CYC, LOCK_STABLE_CYC),
                                     LOCK_TIMEOUT_CYC);
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    state_t              state;
    state_t              state_nxt;
    logic [TIMER_W-1:0]  timer;
    logic                lock_s;
    logic                timer_run;
    logic                wait_timeout;
    logic                loss_evt;
    logic                cfg_fire;
    logic [RETRY_W-1:0]  retry_inc;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clkin),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

`ifdef PLL_SUPERVISOR_DYN_EN
    assign cfg_fire = cfg_valid && cfg_ready;
`else
    assign cfg_fire = 1'b0;
`endif

    assign timer_run    = (state == ST_RST) || (state == ST_RECONF) ||
                          (state == ST_WAIT_LOCK) || (state == ST_STABLE);
    assign wait_timeout = (state == ST_WAIT_LOCK) && !lock_s && (timer == TIMEOUT_LAST);
    assign loss_evt     = (state == ST_RUN) && !lock_s;
    assign retry_inc    = retry_cnt + RETRY_W'(1);
    assign state_o      = state;

    // Next-state decision. In WAIT_LOCK the lock test comes first so a lock
    // arriving on the very last timeout cycle still counts as success. In RUN
    // an accepted reconfiguration wins over a simultaneous lock loss, since
    // RECONF re-sequences the PLL anyway.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST, ST_RECONF: begin
                if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)            state_nxt = ST_STABLE;
                else if (wait_timeout) state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RST;
            end
            ST_STABLE: begin
                if (!lock_s)                   state_nxt = ST_WAIT_LOCK;
                else if (timer == STABLE_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cfg_fire)     state_nxt = ST_RECONF;
                else if (!lock_s) state_nxt = ST_RST;
            end
            ST_FAIL: begin
                if (cfg_fire) state_nxt = ST_RECONF;
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // State, timer, counters and outputs. Outputs are decoded from the next
    // state so they change on the same edge as the state register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_RST;
            timer         <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            pll_reset     <= 1'b1;
            sys_rst_n     <= 1'b0;
            pll_ready     <= 1'b0;
            pll_fail      <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                timer <= '0;
            end else if (timer_run) begin
                timer <= timer + TIMER_W'(1);
            end

            if ((state_nxt == ST_RUN) || cfg_fire) begin
                retry_cnt <= '0;
            end else if (wait_timeout && !lock_s) begin
                retry_cnt <= retry_inc;
            end

            if (loss_evt && (lock_loss_cnt != '1)) begin
                lock_loss_cnt <= lock_loss_cnt + LOSS_W'(1);
            end

            pll_reset <= holds_pll_reset(state_nxt);
            sys_rst_n <= (state_nxt == ST_RUN);
            pll_ready <= (state_nxt == ST_RUN);
            pll_fail  <= (state_nxt == ST_FAIL);
        end
    end

`ifdef PLL_SUPERVISOR_DYN_EN
    // Divider selects are captured on an accepted request; cfg_ready is
    // offered only where a reprogram is safe (RUN) or the only way out (FAIL).
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready  <= 1'b0;
            pll_idsel  <= '0;
            pll_fbdsel <= '0;
            pll_odsel  <= '0;
        end else begin
            cfg_ready <= (state_nxt == ST_RUN) || (state_nxt == ST_FAIL);
            if (cfg_fire) begin
                pll_idsel  <= cfg_idsel;
                pll_fbdsel <= cfg_fbdsel;
                pll_odsel  <= cfg_odsel;
            end
        end
    end
`endif

endmodule
